bilinear_win2x2_gen: RTL and testbench

Streaming 2x2 neighbourhood generator that feeds the bilinear 3x upscale target calculators. It accepts a raster-order source pixel stream and buffers one line internally. For every source pixel P(r,c) it emits exactly one window {P(r,c), P(r,c+1), P(r+1,c), P(r+1,c+1)}, each window paired with a single-cycle calc_en. Right and bottom borders are handled by edge replication, so each frame produces W*H windows.

---
 rtl/bilinear_win2x2_gen.sv | 204 ++++++++++++++++++++
 tb/tb_bilinear_win2x2_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_win2x2_gen.sv
// bilinear_win2x2_gen
// Streaming 2x2 neighbourhood generator for the bilinear 3x upscaler.
// It takes a raster-order pixel stream and keeps one source line in an internal
// buffer. For every source pixel P(r,c) it emits one window
// {P(r,c), P(r,c+1), P(r+1,c), P(r+1,c+1)} with a single-cycle calc_en.
// Right and bottom borders use edge replication, so a W x H frame gives W*H windows.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   frame_start             start pulse, only looked at while idle
//   img_width, img_height   frame size W (1..MAX_WIDTH) and H (>=1), latched at frame_start
//   pix_i, pix_valid_i      source pixel stream
//   pix_ready_o             a pixel is taken when pix_valid_i & pix_ready_o
//   calc_en                 window valid strobe
//   buf00/buf10/buf01/buf11 P(r,c), P(r,c+1), P(r+1,c), P(r+1,c+1), indices clamped
//   win_col, win_row        position (c,r) of the emitted window
//   frame_done              pulses together with the last window of a frame
module bilinear_win2x2_gen #(
  parameter int DW            = 8,
  parameter int ROW_CNT_WIDTH = 12,
  parameter int COL_CNT_WIDTH = 12,
  parameter int MAX_WIDTH     = 1920
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [COL_CNT_WIDTH-1:0] img_width,
  input  logic [ROW_CNT_WIDTH-1:0] img_height,
  input  logic [DW-1:0]            pix_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  output logic                     calc_en,
  output logic [DW-1:0]            buf00,
  output logic [DW-1:0]            buf10,
  output logic [DW-1:0]            buf01,
  output logic [DW-1:0]            buf11,
  output logic [COL_CNT_WIDTH-1:0] win_col,
  output logic [ROW_CNT_WIDTH-1:0] win_row,
  output logic                     frame_done
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_EDGE,
    S_FLUSH
  } state_t;

  state_t                   r_state;
  logic [COL_CNT_WIDTH-1:0] r_wm1;     // W-1
  logic [ROW_CNT_WIDTH-1:0] r_hm1;     // H-1
  logic [COL_CNT_WIDTH-1:0] r_col;     // column of the pixel being accepted / flushed
  logic [ROW_CNT_WIDTH-1:0] r_row;     // row r of the windows being produced
  logic [DW-1:0]            r_prev_top; // P(r,c-1): previous line-buffer read
  logic [DW-1:0]            r_prev_bot; // P(r+1,c-1): previous accepted pixel
  logic [DW-1:0]            r_line [0:MAX_WIDTH-1];

  logic                     w_acc;
  logic                     w_col_last;
  logic [COL_CNT_WIDTH-1:0] w_col_nxt;
  logic [AW-1:0]            w_addr;
  logic [AW-1:0]            w_addr_nxt;
  logic [DW-1:0]            w_rd0;
  logic [DW-1:0]            w_rd1;

  assign w_acc      = pix_valid_i & pix_ready_o;
  assign w_col_last = (r_col == r_wm1);
  // Column clamped to W-1; doubles as the counter increment while not at the end.
  assign w_col_nxt  = w_col_last ? r_col : r_col + 1'b1;
  assign w_addr     = r_col[AW-1:0];
  assign w_addr_nxt = w_col_nxt[AW-1:0];
  assign w_rd0      = r_line[w_addr];
  assign w_rd1      = r_line[w_addr_nxt];

  // Line buffer: row 0 is written during FILL; during STREAM each incoming pixel
  // overwrites P(r,c) after it has been read, so the buffer always holds the
  // newest complete row by the time FLUSH starts.
  always_ff @(posedge clk) begin
    if (w_acc && (r_state == S_FILL || r_state == S_STREAM)) begin
      r_line[w_addr] <= pix_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wm1       <= '0;
      r_hm1       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_prev_top  <= '0;
      r_prev_bot  <= '0;
      pix_ready_o <= 1'b0;
      calc_en     <= 1'b0;
      frame_done  <= 1'b0;
      buf00       <= '0;
      buf10       <= '0;
      buf01       <= '0;
      buf11       <= '0;
      win_col     <= '0;
      win_row     <= '0;
    end else begin
      calc_en    <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_wm1       <= img_width - 1'b1;
            r_hm1       <= img_height - 1'b1;
            r_col       <= '0;
            r_row       <= '0;
            r_state     <= S_FILL;
            pix_ready_o <= 1'b1;
          end
        end

        S_FILL: begin
          if (w_acc) begin
            if (w_col_last) begin
              r_col <= '0;
              if (r_hm1 == '0) begin
                r_state     <= S_FLUSH;
                pix_ready_o <= 1'b0;
              end else begin
                r_state <= S_STREAM;
              end
            end else begin
              r_col <= w_col_nxt;
            end
          end
        end

        S_STREAM: begin
          if (w_acc) begin
            // Pixel (r+1,c) completes window (r,c-1).
            if (r_col != '0) begin
              calc_en <= 1'b1;
              buf00   <= r_prev_top;
              buf10   <= w_rd0;
              buf01   <= r_prev_bot;
              buf11   <= pix_i;
              win_col <= r_col - 1'b1;
              win_row <= r_row;
            end
            r_prev_top <= w_rd0;
            r_prev_bot <= pix_i;
            if (w_col_last) begin
              r_state     <= S_EDGE;
              pix_ready_o <= 1'b0;
            end else begin
              r_col <= w_col_nxt;
            end
          end
        end

        S_EDGE: begin
          // Right-border window: replicate column W-1.
          calc_en <= 1'b1;
          buf00   <= r_prev_top;
          buf10   <= r_prev_top;
          buf01   <= r_prev_bot;
          buf11   <= r_prev_bot;
          win_col <= r_wm1;
          win_row <= r_row;
          r_col   <= '0;
          r_row   <= r_row + 1'b1;
          if (r_row + 1'b1 == r_hm1) begin
            r_state <= S_FLUSH;
          end else begin
            r_state     <= S_STREAM;
            pix_ready_o <= 1'b1;
          end
        end

        S_FLUSH: begin
          // Bottom row: replicate row H-1 straight from the line buffer.
          calc_en <= 1'b1;
          buf00   <= w_rd0;
          buf10   <= w_rd1;
          buf01   <= w_rd0;
          buf11   <= w_rd1;
          win_col <= r_col;
          win_row <= r_row;
          if (w_col_last) begin
            frame_done <= 1'b1;
            r_col      <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_col <= w_col_nxt;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          pix_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bilinear_win2x2_gen.sv
module tb_bilinear_win2x2_gen;

  localparam int DW     = 8;
  localparam int RW     = 12;
  localparam int CW     = 12;
  localparam int MAXW   = 1920;
  localparam int NPIX   = MAXW * 4;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic [CW-1:0] img_width;
  logic [RW-1:0] img_height;
  logic [DW-1:0] pix_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic          calc_en;
  logic [DW-1:0] buf00, buf10, buf01, buf11;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          frame_done;

  bilinear_win2x2_gen #(
    .DW(DW), .ROW_CNT_WIDTH(RW), .COL_CNT_WIDTH(CW), .MAX_WIDTH(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .img_width(img_width), .img_height(img_height),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .calc_en(calc_en), .buf00(buf00), .buf10(buf10), .buf01(buf01), .buf11(buf11),
    .win_col(win_col), .win_row(win_row), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [55:0] win;   // {buf00, buf10, buf01, buf11, win_row, win_col}
    logic        last;
  } exp_t;

  exp_t          q[$];
  exp_t          e_mon;
  logic [DW-1:0] fr [0:NPIX-1];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_win    = 0;
  int            n_done   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: every source pixel yields one window with clamped neighbours.
  task automatic build_expected(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int   c1, r1;
        exp_t e;
        c1 = (c + 1 < w) ? c + 1 : w - 1;
        r1 = (r + 1 < h) ? r + 1 : h - 1;
        e.win  = {fr[r*w+c], fr[r*w+c1], fr[r1*w+c], fr[r1*w+c1], RW'(r), CW'(c)};
        e.last = (r == h - 1) && (c == w - 1);
        q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (calc_en) begin
        n_win++;
        if (frame_done) n_done++;
        if (q.size() == 0) begin
          chk("extra_win", 64'(q.size()), 64'd1);
        end else begin
          e_mon = q.pop_front();
          chk("win", {8'h0, buf00, buf10, buf01, buf11, win_row, win_col}, {8'h0, e_mon.win});
          chk("done_flag", 64'(frame_done), 64'(e_mon.last));
        end
      end else if (frame_done) begin
        chk("done_without_en", 64'(calc_en), 64'd1);
      end
    end
  end

  // Drives one frame; stop_after >= 0 abandons the frame after that many pixels.
  task automatic run_frame(input int w, input int h, input bit rnd, input bit gaps,
                           input bit fs_flush, input int stop_after);
    int idx = 0;
    int cyc = 0;
    bit edge_pend = 0;
    bit rdy_hi_chk = 0;
    if (rnd) for (int i = 0; i < w * h; i++) fr[i] = DW'($urandom);
    build_expected(w, h);
    n_win  = 0;
    n_done = 0;
    @(negedge clk);
    frame_start = 1'b1;
    img_width   = CW'(w);
    img_height  = RW'(h);
    @(negedge clk);
    frame_start = 1'b0;
    while (idx < w * h && (stop_after < 0 || idx < stop_after)) begin
      if (rdy_hi_chk) begin
        chk("ready_resume", 64'(pix_ready_o), 64'd1);
        rdy_hi_chk = 0;
      end
      pix_valid_i = gaps ? ($urandom_range(2) != 0) : 1'b1;
      pix_i       = fr[idx];
      if (pix_valid_i && pix_ready_o) begin
        if ((idx % w) == w - 1 && idx / w >= 1 && idx / w < h - 1) edge_pend = 1;
        idx++;
      end
      @(negedge clk);
      if (edge_pend) begin
        chk("ready_edge", 64'(pix_ready_o), 64'd0);
        pix_valid_i = 1'b0;
        edge_pend   = 0;
        rdy_hi_chk  = 1;
        @(negedge clk);
      end
      cyc++;
      if (cyc > 4 * NPIX) begin
        chk("timeout_input", 64'(idx), 64'(w * h));
        break;
      end
    end
    pix_valid_i = 1'b0;
    if (stop_after >= 0) return;
    if (fs_flush) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
    cyc = 0;
    while (n_done == 0 && cyc < 2 * MAXW + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("frame_done_seen", 64'(n_done != 0), 64'd1);
    repeat (4) @(negedge clk);
    chk("win_count", 64'(n_win), 64'(w * h));
    chk("done_count", 64'(n_done), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("idle_ready", 64'(pix_ready_o), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    img_width   = '0;
    img_height  = '0;
    pix_i       = '0;
    pix_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {pix_ready_o, calc_en, frame_done, buf00, buf10, buf01, buf11, win_col, win_row}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3x2, pixels 1..6
    for (int i = 0; i < 6; i++) fr[i] = DW'(i + 1);
    run_frame(3, 2, 0, 0, 0, -1);

    // 1x1, pixel 0x7F
    fr[0] = 8'h7F;
    run_frame(1, 1, 0, 0, 0, -1);

    // 4x3 with input gaps, twice
    run_frame(4, 3, 1, 1, 0, -1);
    run_frame(4, 3, 1, 1, 0, -1);

    // Abandon an 8x8 frame in STREAM with a reset
    run_frame(8, 8, 1, 0, 0, 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_out", {pix_ready_o, calc_en, frame_done, buf00, buf10, buf01, buf11, win_col, win_row}, 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fr[0] = 8'd9; fr[1] = 8'd8; fr[2] = 8'd7; fr[3] = 8'd6;
    run_frame(2, 2, 0, 0, 0, -1);

    // frame_start during FLUSH must be ignored
    run_frame(5, 2, 1, 0, 1, -1);

    // Degenerate shapes
    run_frame(1, 4, 1, 1, 0, -1);
    run_frame(7, 1, 1, 1, 0, -1);

    // Full width
    run_frame(MAXW, 4, 1, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
